// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run-control sequencer between the monitor command decoder and cpu_status.
// Turns decoded commands into cpu_start/quit_cmd pulses, holds the start address, gates
// start on DDR calibration and counts retired (non-stall) cycles.
// Optional PC breakpoint: define RUN_CTRL_BRK_EN.
module cpu_run_ctrl #(
    parameter int unsigned DRAIN_CYC = 5,
    parameter logic [31:0] ADR_RST   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_code,
    input  logic [31:0] cmd_data,
    input  logic        init_calib_complete,
    input  logic        stall,
    input  logic [31:0] pc_id,
    output logic        cpu_start,
    output logic        quit_cmd,
    output logic [31:0] start_adr,
    output logic        running,
    output logic        done,
    output logic        cmd_err,
    output logic [31:0] cycle_cnt
);

    localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_CAL = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_QUIT     = 3'd4;
    localparam logic [2:0] S_DRAIN    = 3'd5;

    localparam logic [2:0] CMD_NOP    = 3'd0;
    localparam logic [2:0] CMD_SETADR = 3'd1;
    localparam logic [2:0] CMD_RUN    = 3'd2;
    localparam logic [2:0] CMD_RUNN   = 3'd3;
    localparam logic [2:0] CMD_QUIT   = 3'd4;
    localparam logic [2:0] CMD_SETBRK = 3'd5;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [DW-1:0] drain_cnt;
    logic [31:0]   budget;
    logic [31:0]   budget_d;
    logic [31:0]   cnt_inc;
    logic          accept;
    logic          budget_hit;
    logic          brk_hit;
    logic          err_nxt;
    logic          done_nxt;
    logic          adr_we;
    logic          budget_we;

    // Commands are only taken in the states that can act on (or reject) them
    assign cmd_ready = (state == S_IDLE) || (state == S_WAIT_CAL) || (state == S_RUN);
    assign accept    = cmd_valid & cmd_ready;

    // Saturating increment and budget compare against the post-increment count
    assign cnt_inc    = (cycle_cnt == 32'hFFFF_FFFF) ? cycle_cnt : cycle_cnt + 32'd1;
    assign budget_hit = (budget != 32'd0) && !stall && (cnt_inc == budget);

`ifdef RUN_CTRL_BRK_EN
    logic [31:0] brk_adr;
    logic        brk_en;
    logic        brk_we;

    assign brk_hit = !stall && brk_en && (pc_id == brk_adr);

    // Breakpoint address register; all-ones disarms it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_adr <= 32'd0;
            brk_en  <= 1'b0;
        end else if (brk_we) begin
            brk_adr <= cmd_data;
            brk_en  <= (cmd_data != 32'hFFFF_FFFF);
        end
    end
`else
    logic unused_pc;

    assign brk_hit   = 1'b0;
    assign unused_pc = ^pc_id;
`endif

    // Next-state and command decode
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        adr_we    = 1'b0;
        budget_we = 1'b0;
        budget_d  = budget;
`ifdef RUN_CTRL_BRK_EN
        brk_we    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_code)
                        CMD_SETADR: adr_we = 1'b1;
                        CMD_RUN, CMD_RUNN: begin
                            budget_we = 1'b1;
                            budget_d  = (cmd_code == CMD_RUNN) ? cmd_data : 32'd0;
                            state_nxt = init_calib_complete ? S_START : S_WAIT_CAL;
                        end
`ifdef RUN_CTRL_BRK_EN
                        CMD_SETBRK: brk_we = 1'b1;
`else
                        CMD_SETBRK: err_nxt = 1'b1;
`endif
                        CMD_NOP, CMD_QUIT: begin
                        end
                        default: err_nxt = 1'b1;
                    endcase
                end
            end
            S_WAIT_CAL: begin
                if (accept && (cmd_code == CMD_QUIT)) begin
                    state_nxt = S_IDLE;
                end else begin
                    err_nxt = accept;
                    if (init_calib_complete) begin
                        state_nxt = S_START;
                    end
                end
            end
            S_START: state_nxt = S_RUN;
            S_RUN: begin
                err_nxt = accept && (cmd_code != CMD_QUIT);
                if ((accept && (cmd_code == CMD_QUIT)) || budget_hit || brk_hit ||
                    !init_calib_complete) begin
                    state_nxt = S_QUIT;
                end
            end
            S_QUIT: state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered pulses, status, address/budget holding and retired-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_start <= 1'b0;
            quit_cmd  <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            start_adr <= ADR_RST;
            budget    <= 32'd0;
            cycle_cnt <= 32'd0;
            drain_cnt <= '0;
        end else begin
            cpu_start <= (state_nxt == S_START);
            quit_cmd  <= (state_nxt == S_QUIT);
            running   <= (state_nxt == S_START) || (state_nxt == S_RUN);
            done      <= done_nxt;
            cmd_err   <= err_nxt;
            if (adr_we) begin
                start_adr <= cmd_data;
            end
            if (budget_we) begin
                budget <= budget_d;
            end
            if (state == S_START) begin
                cycle_cnt <= 32'd0;
            end else if ((state == S_RUN) && !stall) begin
                cycle_cnt <= cnt_inc;
            end
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + DW'(1) : '0;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed vector table, hand-written multi-cycle sequences and
// random stimulus compared every cycle against a behavioural model.
module tb_cpu_run_ctrl;

    localparam int DRAIN = 5;
    localparam logic [2:0] NOP = 3'd0, SETADR = 3'd1, RUN = 3'd2, RUNN = 3'd3,
                           QUIT = 3'd4, SETBRK = 3'd5;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_code;
    logic [31:0] cmd_data;
    logic        init_calib_complete, stall;
    logic [31:0] pc_id;
    logic        cpu_start, quit_cmd, running, done, cmd_err;
    logic [31:0] start_adr, cycle_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_run_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_data(cmd_data), .init_calib_complete(init_calib_complete),
        .stall(stall), .pc_id(pc_id), .cpu_start(cpu_start), .quit_cmd(quit_cmd),
        .start_adr(start_adr), .running(running), .done(done), .cmd_err(cmd_err),
        .cycle_cnt(cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Behavioural model: a run request, a one-cycle start phase, an active run and a
    // shutdown countdown covering the quit pulse plus the drain window.
    bit          m_wait, m_first, m_active, m_done, m_err, m_brk_en;
    int          m_shut;
    logic [31:0] m_adr, m_cnt, m_budget, m_brk_adr;

    function automatic bit m_ready();
        return !m_first && (m_shut == 0);
    endfunction

    task automatic model_reset();
        m_wait = 0; m_first = 0; m_active = 0; m_done = 0; m_err = 0; m_brk_en = 0;
        m_shut = 0; m_adr = 32'h0; m_cnt = 32'h0; m_budget = 32'h0; m_brk_adr = 32'h0;
    endtask

    task automatic model_step(input logic v, input logic [2:0] c, input logic [31:0] d,
                              input logic cal, input logic st, input logic [31:0] pc);
        bit acc, hit, brk;
        acc = v && m_ready();
        m_done = 0;
        m_err  = 0;
`ifdef RUN_CTRL_BRK_EN
        brk = m_brk_en && !st && (pc == m_brk_adr);
`else
        brk = 0;
`endif
        if (m_shut > 0) begin
            m_shut--;
            if (m_shut == 0) m_done = 1;
        end else if (m_first) begin
            m_first = 0;
            m_cnt   = 0;
        end else if (m_active) begin
            if (!st && m_cnt != 32'hFFFF_FFFF) m_cnt++;
            hit = (m_budget != 0) && !st && (m_cnt == m_budget);
            if (acc && c != QUIT) m_err = 1;
            if ((acc && c == QUIT) || hit || !cal || brk) begin
                m_active = 0;
                m_shut   = DRAIN + 1;
            end
        end else if (m_wait) begin
            if (acc && c == QUIT) begin
                m_wait = 0;
            end else begin
                if (acc) m_err = 1;
                if (cal) begin
                    m_wait = 0; m_first = 1; m_active = 1;
                end
            end
        end else if (acc) begin
            if (c == SETADR) m_adr = d;
            else if (c == RUN || c == RUNN) begin
                m_budget = (c == RUNN) ? d : 32'h0;
                if (cal) begin m_first = 1; m_active = 1; end
                else m_wait = 1;
            end else if (c == SETBRK) begin
`ifdef RUN_CTRL_BRK_EN
                m_brk_adr = d;
                m_brk_en  = (d != 32'hFFFF_FFFF);
`else
                m_err = 1;
`endif
            end else if (c > SETBRK) m_err = 1;
        end
    endtask

    task automatic check_model();
        chk("m_cpu_start", {31'h0, cpu_start}, {31'h0, m_first});
        chk("m_quit_cmd",  {31'h0, quit_cmd},  {31'h0, m_shut == DRAIN + 1});
        chk("m_running",   {31'h0, running},   {31'h0, m_active});
        chk("m_done",      {31'h0, done},      {31'h0, m_done});
        chk("m_cmd_err",   {31'h0, cmd_err},   {31'h0, m_err});
        chk("m_cmd_ready", {31'h0, cmd_ready}, {31'h0, m_ready()});
        chk("m_start_adr", start_adr, m_adr);
        chk("m_cycle_cnt", cycle_cnt, m_cnt);
    endtask

    // One clock: drive inputs, advance model at the edge, compare on the falling edge
    task automatic cyc(input logic v, input logic [2:0] c, input logic [31:0] d,
                       input logic cal, input logic st, input logic [31:0] pc);
        cmd_valid = v; cmd_code = c; cmd_data = d;
        init_calib_complete = cal; stall = st; pc_id = pc;
        @(posedge clk);
        model_step(v, c, d, cal, st, pc);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_cyc();
        cyc(1'b0, NOP, 32'h0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic wait_done(input string n);
        bit seen;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            idle_cyc();
            seen = done;
        end
        chk(n, {31'h0, seen}, 32'h1);
    endtask

    typedef struct {
        logic v; logic [2:0] code; logic [31:0] data; logic cal; logic st;
        logic e_start, e_quit, e_run, e_done, e_err, e_rdy; logic [31:0] e_adr;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [2:0] c, input logic [31:0] d,
                                input logic s, input logic q, input logic r, input logic dn,
                                input logic e, input logic rd);
        vec_t t;
        t.v = v; t.code = c; t.data = d; t.cal = 1'b1; t.st = 1'b0;
        t.e_start = s; t.e_quit = q; t.e_run = r; t.e_done = dn; t.e_err = e; t.e_rdy = rd;
        t.e_adr = 32'h100;
        return t;
    endfunction

    vec_t vt[12];

    initial begin
        int k;
        bit seen;
        // v code data | start quit run done err ready
        vt[0]  = mk(1, SETADR, 32'h100, 0, 0, 0, 0, 0, 1);
        vt[1]  = mk(1, RUN,    32'h0,   1, 0, 1, 0, 0, 0);
        vt[2]  = mk(0, NOP,    32'h0,   0, 0, 1, 0, 0, 1);
        vt[3]  = mk(1, SETADR, 32'h55,  0, 0, 1, 0, 1, 1);
        vt[4]  = mk(1, QUIT,   32'h0,   0, 1, 0, 0, 0, 0);
        for (int i = 5; i < 10; i++) vt[i] = mk(0, NOP, 32'h0, 0, 0, 0, 0, 0, 0);
        vt[10] = mk(0, NOP,    32'h0,   0, 0, 0, 1, 0, 1);
        vt[11] = mk(0, NOP,    32'h0,   0, 0, 0, 0, 0, 1);

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_code = NOP; cmd_data = 32'h0;
        init_calib_complete = 1'b1; stall = 1'b0; pc_id = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_model();
        rst_n = 1'b1;

        // Directed table: SETADR, RUN, command in RUN, QUIT, drain, done
        for (int i = 0; i < 12; i++) begin
            cyc(vt[i].v, vt[i].code, vt[i].data, vt[i].cal, vt[i].st, 32'h0);
            chk($sformatf("vec%0d_start", i), {31'h0, cpu_start}, {31'h0, vt[i].e_start});
            chk($sformatf("vec%0d_quit", i),  {31'h0, quit_cmd},  {31'h0, vt[i].e_quit});
            chk($sformatf("vec%0d_run", i),   {31'h0, running},   {31'h0, vt[i].e_run});
            chk($sformatf("vec%0d_done", i),  {31'h0, done},      {31'h0, vt[i].e_done});
            chk($sformatf("vec%0d_err", i),   {31'h0, cmd_err},   {31'h0, vt[i].e_err});
            chk($sformatf("vec%0d_rdy", i),   {31'h0, cmd_ready}, {31'h0, vt[i].e_rdy});
            chk($sformatf("vec%0d_adr", i),   start_adr,          vt[i].e_adr);
        end

        // RUNN 10 without stalls: quit after 10 retired cycles, done after drain
        cyc(1, RUNN, 32'd10, 1, 0, 32'h0);
        k = 0; seen = 0;
        while (!seen && k < 40) begin idle_cyc(); k++; seen = quit_cmd; end
        chk("runn10_quit_cycle", k, 11);
        chk("runn10_cnt", cycle_cnt, 32'd10);
        k = 0; seen = 0;
        while (!seen && k < 40) begin idle_cyc(); k++; seen = done; end
        chk("runn10_done_delay", k, DRAIN + 1);
        chk("runn10_cnt_hold", cycle_cnt, 32'd10);

        // RUN without calibration waits, then starts once calibration completes
        cyc(1, RUN, 32'h0, 0, 0, 32'h0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, NOP, 32'h0, 0, 0, 32'h0);
            seen = seen | cpu_start;
        end
        chk("waitcal_no_start", {31'h0, seen}, 32'h0);
        cyc(0, NOP, 32'h0, 1, 0, 32'h0);
        chk("waitcal_start", {31'h0, cpu_start}, 32'h1);
        idle_cyc();
        cyc(1, QUIT, 32'h0, 1, 0, 32'h0);
        chk("waitcal_quit", {31'h0, quit_cmd}, 32'h1);
        wait_done("waitcal_done");

        // RUNN 4 with stall toggling: only non-stall cycles count
        cyc(1, RUNN, 32'd4, 1, 0, 32'h0);
        k = 0; seen = 0;
        while (!seen && k < 40) begin
            k++;
            cyc(0, NOP, 32'h0, 1, (k % 2 == 0), 32'h0);
            seen = quit_cmd;
        end
        chk("runn4_quit_cycle", k, 9);
        chk("runn4_cnt", cycle_cnt, 32'd4);
        wait_done("runn4_done");

        // QUIT while waiting for calibration returns to idle without pulses
        cyc(1, RUN, 32'h0, 0, 0, 32'h0);
        cyc(1, QUIT, 32'h0, 0, 0, 32'h0);
        chk("wcquit_no_start", {31'h0, cpu_start}, 32'h0);
        chk("wcquit_no_quit", {31'h0, quit_cmd}, 32'h0);
        chk("wcquit_ready", {31'h0, cmd_ready}, 32'h1);
        repeat (3) cyc(0, NOP, 32'h0, 0, 0, 32'h0);
        cyc(1, RUN, 32'h0, 1, 0, 32'h0);
        chk("wcquit_idle_restart", {31'h0, cpu_start}, 32'h1);
        idle_cyc();
        cyc(1, QUIT, 32'h0, 1, 0, 32'h0);
        wait_done("wcquit_done");

`ifdef RUN_CTRL_BRK_EN
        // Breakpoint only fires on a non-stalled cycle
        cyc(1, SETBRK, 32'h40, 1, 0, 32'h0);
        cyc(1, RUN, 32'h0, 1, 0, 32'h0);
        idle_cyc();
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, NOP, 32'h0, 1, 1, 32'h40);
            seen = seen | quit_cmd;
        end
        chk("brk_stall_no_quit", {31'h0, seen}, 32'h0);
        cyc(0, NOP, 32'h0, 1, 0, 32'h40);
        chk("brk_quit", {31'h0, quit_cmd}, 32'h1);
        wait_done("brk_done");
        cyc(1, SETBRK, 32'hFFFF_FFFF, 1, 0, 32'h0);
`else
        // Without the breakpoint option SETBRK is rejected
        cyc(1, SETBRK, 32'h40, 1, 0, 32'h0);
        chk("setbrk_err", {31'h0, cmd_err}, 32'h1);
        idle_cyc();
`endif

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  c;
            logic [31:0] d;
            c = 3'($urandom_range(0, 7));
            if (c == RUNN) d = 32'($urandom_range(0, 15));
            else if (c == SETBRK) d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF
                                                                  : 32'($urandom_range(0, 7));
            else d = $urandom;
            cyc(($urandom_range(0, 2) == 0), c, d, ($urandom_range(0, 15) != 0),
                ($urandom_range(0, 2) == 0), 32'($urandom_range(0, 7)));
        end

        // Asynchronous reset in the middle of a run
        for (int i = 0; i < 30; i++) idle_cyc();
        cyc(1, SETADR, 32'h200, 1, 0, 32'h0);
        cyc(1, RUN, 32'h0, 1, 0, 32'h0);
        idle_cyc();
        idle_cyc();
        chk("rst_pre_running", {31'h0, running}, 32'h1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        chk("rst_adr", start_adr, 32'h0);
        #1;
        rst_n = 1'b1;
        idle_cyc();
        chk("rst_no_quit", {31'h0, quit_cmd}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
